bcd_stopwatch: RTL
==================

Name: bcd_stopwatch

Overview:
Downstream consumer of the slow-clock divider output. Samples the divider's toggling `divided_Clock` level in the fast `clock` domain and rising-edge detects it. Advances a NUM_DIGITS-digit BCD counter, one count per slow-clock rising edge, under start/stop/clear control from board keys. Drives active-low seven-segment outputs for the DE10-class HEX displays.

Parameters:
NUM_DIGITS, 4, number of BCD digits counted and displayed (1..6)

Ports:
clock  input  1  system clock, same clock that drives the divider
reset_n  input  1  asynchronous, active-low reset
slow_clk  input  1  divided_Clock level from the divider; one count per rising edge
start_stop  input  1  active-high key level, raw (not synchronised)
clear  input  1  active-high key level, raw (not synchronised)
bcd  output  4*NUM_DIGITS  count value; digit 0 in bits [3:0], least significant
hex  output  7*NUM_DIGITS  segments per digit {g,f,e,d,c,b,a}, active-low; digit 0 in [6:0]
running  output  1  high while in RUN
overflow  output  1  sticky; set on wrap from all-9s to zero

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; bcd all zero; running 0; overflow 0.
  - Every hex digit = 7'b1000000 ("0").
  - All sync and edge registers cleared.
- Reset mid-count returns to these values immediately, with no tick or event pending.
- slow_clk handling:
  - Registered once into slow_q, then slow_prev.
  - tick = slow_q & ~slow_prev.
  - Count updates at the 2nd clock edge after slow_clk is first sampled high.
  - Exactly one tick per slow_clk rising edge, however long the high phase.
- Keys:
  - Each key passes through a 2-flop synchroniser, then a prev flop.
  - Event = sync2 & ~prev (one event per press, however long held).
  - State changes at the 3rd clock edge after the key is first sampled high.
- States: IDLE, RUN, PAUSE.
  - IDLE --start_stop--> RUN
  - RUN --start_stop--> PAUSE
  - PAUSE --start_stop--> RUN
  - any state --clear--> IDLE: bcd zero, overflow cleared.
- Counting happens only when tick occurs and state is RUN (including the cycle RUN is exited).
- BCD arithmetic:
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit.
  - Digits never hold A-F.
  - All digits 9 + tick: bcd becomes all zero, overflow set, state stays RUN.
- Simultaneous events:
  - clear + anything: clear wins; IDLE, zero, no increment.
  - tick + start_stop in RUN: increment applied AND go to PAUSE.
  - tick + start_stop in PAUSE: no increment; go to RUN.
  - tick + start_stop in IDLE: no increment; go to RUN.
- Timing of outputs:
  - running = (state == RUN), registered.
  - hex is a combinational decode of registered bcd; no extra latency.
- Segment codes (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other value = 1111111 (blank).

Optional Feature:
- Macro: LAP_HOLD_EN.
- With the macro defined:
  - Adds input port lap (raw, active-high), synchronised and edge-detected like the keys.
  - A lap event in RUN freezes hex to the bcd value at that edge; counting continues.
  - A second lap event, any start_stop event, or clear unfreezes, and hex tracks bcd again.
  - lap in IDLE or PAUSE is ignored.
  - bcd always shows the live count.
- Without the macro: no lap port; hex always tracks bcd.

Decomposition:
- Package stopwatch_pkg:
  - state enum (IDLE, RUN, PAUSE);
  - SEG_BLANK and SEG_DIGIT[0:9] constants;
  - BCD_MAX digit constant (4'd9).
- Sub-module seg7_decoder: 4-bit BCD in, 7-bit active-low segments out. Instantiated NUM_DIGITS times via generate.
- Synchroniser and edge detect stay inline.

Test Plan:
- Reset, then 5 slow_clk rising edges without start -> bcd=0000, hex digit0=1000000, running=0.
- start_stop press, then 12 slow_clk edges -> bcd=0x0012, running=1. Holding slow_clk high for 100 cycles yields one count only.
- From RUN at 0x0099: start_stop and tick in the same cycle -> bcd=0x0100, state PAUSE. Further ticks leave 0x0100. start_stop again resumes.
- From RUN at 0x9999: one tick -> bcd=0x0000, overflow=1, running=1. clear -> overflow=0, IDLE.
- clear and start_stop events in the same cycle from PAUSE at 0x0042 -> IDLE, bcd=0000, running=0. Then assert reset_n low mid-RUN -> all outputs at reset values without waiting for a clock edge.
- LAP_HOLD_EN: RUN at 0x0007, lap, then 3 ticks -> hex shows 7 while bcd=0x0010. Second lap -> hex shows 10.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM states and
// active-low seven-segment codes in {g,f,e,d,c,b,a} order.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/seg7_decoder.sv
// One BCD digit to active-low seven-segment pattern; non-decimal codes
// blank the display.
module seg7_decoder
  import stopwatch_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (digit <= BCD_MAX) seg = SEG_DIGIT[digit];
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// BCD stopwatch counting rising edges of the divider's slow clock under
// start/stop/clear keys. Optional lap-hold display freeze: LAP_HOLD_EN.
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    slow_clk,
  input  logic                    start_stop,
  input  logic                    clear,
`ifdef LAP_HOLD_EN
  input  logic                    lap,
`endif
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    running,
  output logic                    overflow
);

  // Event pulses are one clock wide: one per rising edge of the source level.
  logic      slow_q, slow_prev;
  logic [1:0] ss_sync, clr_sync;
  logic      ss_prev, clr_prev;
  logic      tick, ss_ev, clr_ev;

  sw_state_e             state, state_next;
  logic [4*NUM_DIGITS-1:0] bcd_next;
  logic                  ovf_next;
  logic                  carry;
  logic [4*NUM_DIGITS-1:0] display;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slow_q    <= 1'b0;
      slow_prev <= 1'b0;
      ss_sync   <= 2'b00;
      ss_prev   <= 1'b0;
      clr_sync  <= 2'b00;
      clr_prev  <= 1'b0;
    end else begin
      slow_q    <= slow_clk;
      slow_prev <= slow_q;
      ss_sync   <= {ss_sync[0], start_stop};
      ss_prev   <= ss_sync[1];
      clr_sync  <= {clr_sync[0], clear};
      clr_prev  <= clr_sync[1];
    end
  end

  assign tick   = slow_q & ~slow_prev;
  assign ss_ev  = ss_sync[1] & ~ss_prev;
  assign clr_ev = clr_sync[1] & ~clr_prev;

  // Clear dominates; an increment still lands on the edge that leaves RUN.
  always_comb begin
    state_next = state;
    bcd_next   = bcd;
    ovf_next   = overflow;
    carry      = 1'b0;
    if (clr_ev) begin
      state_next = IDLE;
      bcd_next   = '0;
      ovf_next   = 1'b0;
    end else begin
      if (tick && state == RUN) begin
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (carry) begin
            if (bcd[4*i +: 4] >= BCD_MAX) begin
              bcd_next[4*i +: 4] = 4'd0;
            end else begin
              bcd_next[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
              carry              = 1'b0;
            end
          end
        end
        if (carry) ovf_next = 1'b1;
      end
      if (ss_ev) begin
        case (state)
          IDLE:    state_next = RUN;
          RUN:     state_next = PAUSE;
          PAUSE:   state_next = RUN;
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      bcd      <= '0;
      overflow <= 1'b0;
      running  <= 1'b0;
    end else begin
      state    <= state_next;
      bcd      <= bcd_next;
      overflow <= ovf_next;
      running  <= (state_next == RUN);
    end
  end

`ifdef LAP_HOLD_EN
  logic [1:0]              lap_sync;
  logic                    lap_prev, lap_ev, frozen;
  logic [4*NUM_DIGITS-1:0] hold_bcd;

  assign lap_ev = lap_sync[1] & ~lap_prev;

  // Freeze captures the count as it stands before this edge's increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lap_sync <= 2'b00;
      lap_prev <= 1'b0;
      frozen   <= 1'b0;
      hold_bcd <= '0;
    end else begin
      lap_sync <= {lap_sync[0], lap};
      lap_prev <= lap_sync[1];
      if (clr_ev || ss_ev) begin
        frozen <= 1'b0;
      end else if (lap_ev) begin
        if (frozen) begin
          frozen <= 1'b0;
        end else if (state == RUN) begin
          frozen   <= 1'b1;
          hold_bcd <= bcd;
        end
      end
    end
  end

  assign display = frozen ? hold_bcd : bcd;
`else
  assign display = bcd;
`endif

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_seg
    seg7_decoder u_seg (
      .digit (display[4*d +: 4]),
      .seg   (hex[7*d +: 7])
    );
  end

endmodule
